multiplex_arb: RTL and testbench
================================

Name: multiplex_arb

Overview:
- Parametrised N-channel selector/arbiter for the transaction layer; successor to the fixed 4-way, 12-bit registered selector.
- Merges NUM_CH valid/ready source channels into one registered output stream, with a per-channel ready handshake.
- Selection is fixed-priority or round-robin (parameter MODE); downstream back-pressure is honoured.
- Output clears while the transaction-layer state input equals the idle code.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 12, payload width per channel.
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- STATE_W, 4, width of the state input.
- IDLE_STATE, 4'b0001, state code that flushes and blocks the block.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- state  in  STATE_W  transaction-layer state; equal to IDLE_STATE means flush.
- in_data  in  NUM_CH*DATA_W  flattened payloads; channel i is bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel accept (combinational, one-hot or zero).
- out_data  out  DATA_W  registered selected payload.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts when high with out_valid.
- out_ch  out  $clog2(NUM_CH)  source channel of out_data.

Behaviour:
- Reset (reset=1 at a clk edge):
  - out_data=0, out_valid=0, out_ch=0, RR pointer=0.
  - in_ready=0 while reset is high.
- load_en = ~out_valid | out_ready. This is a single output register with no bubble on continuous flow.
- idle = (state == IDLE_STATE).
- Grant (combinational): one-hot over in_valid.
  - MODE 0: lowest set index wins.
  - MODE 1: search starts at the RR pointer, wraps modulo NUM_CH, first set bit wins.
- in_ready[i] = grant[i] & load_en & ~idle & ~reset.
- A transfer on channel i occurs when in_valid[i] & in_ready[i].
- Transfer at edge k: at k+1, out_data=in_data chan i, out_ch=i, out_valid=1. Latency is 1 cycle.
- MODE 1 only: on a transfer from channel i, pointer <= (i+1) mod NUM_CH. Pointer is unchanged on cycles with no transfer.
- Output handshake:
  - out_valid & out_ready with no new transfer: out_valid<=0. out_data and out_ch hold their values.
  - out_valid & ~out_ready: out_data, out_ch and out_valid hold. All in_ready are 0.
  - Simultaneous consume and new transfer: new word replaces the old one, out_valid stays 1, no dead cycle.
- No valid inputs and load_en: out_valid<=0, out_data holds.
- Idle (idle=1):
  - out_data<=0, out_valid<=0, out_ch<=0. Any pending word is dropped.
  - in_ready=0, pointer holds.
  - Idle takes precedence over out_ready and in_valid.
- Reset mid-transfer: pending output is discarded, pointer returns to 0, no in_ready asserted that cycle.
- Sources hold in_valid/in_data until accepted; the block never drops an accepted word except on idle or reset.
- Wrap: with pointer=NUM_CH-1 and only channel 0 valid, channel 0 is granted and pointer becomes 1.
- Non-power-of-2 NUM_CH is supported; the pointer never holds a value >= NUM_CH.

Decomposition:
- Shared package transaction_pkg holds:
  - MODE_FIXED=0, MODE_RR=1;
  - state encodings, including ST_IDLE=4'b0001;
  - a clog2-based CH_IDX_W helper.
- Sub-module arb_rr_core is purely combinational: inputs req[NUM_CH], ptr, mode; outputs one-hot grant and binary index.
- The top level holds the output register, pointer register, handshake and idle logic.

Test Plan:
- NUM_CH=4, DATA_W=12, MODE 0. Reset, then in_valid=4'b1010, in_data ch1=12'hABC, ch3=12'h123, out_ready=1 -> in_ready=4'b0010. Next cycle out_data=12'hABC, out_ch=1, out_valid=1.
- MODE 1, all four valid constantly, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_valid stays 1 throughout.
- Back-pressure: out_valid=1 with ch2=12'h055 and out_ready=0 for 3 cycles -> out_data holds 12'h055 and in_ready=0 throughout. When out_ready=1 with ch0 valid (12'h011), the next cycle shows 12'h011.
- state=4'b0001 while out_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=0 while in_valid=4'b1111. When state returns to 4'b0010, the grant resumes from the held pointer.
- RR wrap: pointer=3 (after a ch2 transfer), only ch0 valid -> ch0 granted and next grant search starts at 1. Ch1 and ch0 both valid then -> ch1 granted first.
- Synchronous reset asserted while out_valid=1 and in_valid=4'b0100 -> next cycle out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset; the first post-reset grant comes from pointer 0.

Source files
------------

// File: rtl/multiplex_arb_pkg.sv
// Shared transaction-layer definitions: arbitration modes, state codes and
// the channel-index width helper used by the selector/arbiter.
package transaction_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam logic [3:0] ST_RESET  = 4'b0000;
  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ACTIVE = 4'b0010;
  localparam logic [3:0] ST_DRAIN  = 4'b0100;

  // Width of a channel index; a single-channel build still gets one bit.
  function automatic int ch_idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/arb_rr_core.sv
// Combinational request arbiter: fixed priority from index 0, or a
// rotating search that starts at the round-robin pointer.
module arb_rr_core #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] start;
  logic             found;

  // Channel visited at step k of the search, wrapped modulo NUM_CH.
  function automatic int wrap_idx(input int s, input int k, input int n);
    if (s + k >= n) begin
      return s + k - n;
    end else begin
      return s + k;
    end
  endfunction

  assign start = mode ? ptr : '0;

  // First requesting channel in search order wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[wrap_idx(int'(start), k, NUM_CH)]) begin
        grant[wrap_idx(int'(start), k, NUM_CH)] = 1'b1;
        idx   = IDX_W'(wrap_idx(int'(start), k, NUM_CH));
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/multiplex_arb.sv
// N-channel valid/ready selector with a single registered output stage,
// fixed-priority or round-robin arbitration, and idle-state flush.
module multiplex_arb
  import transaction_pkg::*;
#(
  parameter int                 NUM_CH     = 4,
  parameter int                 DATA_W     = 12,
  parameter int                 MODE       = 0,
  parameter int                 STATE_W    = 4,
  parameter logic [STATE_W-1:0] IDLE_STATE = ST_IDLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [STATE_W-1:0]            state,
  input  logic [NUM_CH*DATA_W-1:0]      in_data,
  input  logic [NUM_CH-1:0]             in_valid,
  output logic [NUM_CH-1:0]             in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ch_idx_w(NUM_CH)-1:0]   out_ch
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic              idle;
  logic              load_en;
  logic              xfer;
  logic              rr_mode;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [DATA_W-1:0] sel_data;

  assign rr_mode = (MODE == MODE_RR) ? 1'b1 : 1'b0;
  assign idle    = (state == IDLE_STATE);
  assign load_en = ~out_valid | out_ready;

  arb_rr_core #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (rr_mode),
    .grant (grant),
    .idx   (gidx)
  );

  // Grant is a subset of in_valid, so any ready bit is a transfer.
  assign in_ready = (load_en & ~idle & ~reset) ? grant : '0;
  assign xfer     = |in_ready;
  assign ptr_next = (gidx == IDX_W'(NUM_CH - 1)) ? '0 : gidx + IDX_W'(1);

  // One-hot payload select.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | ({DATA_W{grant[i]}} & in_data[i*DATA_W +: DATA_W]);
    end
  end

  // Output stage and round-robin pointer; idle overrides handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (idle) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_data  <= sel_data;
      out_valid <= 1'b1;
      out_ch    <= gidx;
      if (MODE == MODE_RR) begin
        ptr <= ptr_next;
      end else begin
        ptr <= ptr;
      end
    end else if (load_en) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_multiplex_arb.sv
// Directed bench: table of vectors against a fixed-priority instance, plus
// hand-written round-robin, wrap, idle and reset sequences.
module tb_multiplex_arb;

  localparam logic [47:0] D = 48'h123_055_ABC_011;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [47:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  ir0, ir1;
  logic [11:0] od0, od1;
  logic        ov0, ov1;
  logic [1:0]  oc0, oc1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multiplex_arb #(.NUM_CH(4), .DATA_W(12), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .state(state), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ir0), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .out_ch(oc0)
  );

  multiplex_arb #(.NUM_CH(4), .DATA_W(12), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .state(state), .in_data(in_data),
    .in_valid(in_valid), .in_ready(ir1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .out_ch(oc1)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  st;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [11:0] od;
    logic [1:0]  oc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [11:0] chan_word(input int ch);
    logic [47:0] d;
    d = D;
    return d[ch*12 +: 12];
  endfunction

  // Drive one cycle, check in_ready before the edge and outputs after it.
  task automatic step(input bit rr, input int idx, input vec_t t);
    @(negedge clk);
    reset     = t.rst;
    state     = t.st;
    in_valid  = t.v;
    out_ready = t.ordy;
    #1;
    chk(rr ? "rr_in_ready" : "in_ready", idx, 16'(rr ? ir1 : ir0), 16'(t.ir));
    @(posedge clk);
    #1;
    chk(rr ? "rr_out_valid" : "out_valid", idx, 16'(rr ? ov1 : ov0), 16'(t.ov));
    chk(rr ? "rr_out_data" : "out_data", idx, 16'(rr ? od1 : od0), 16'(t.od));
    chk(rr ? "rr_out_ch" : "out_ch", idx, 16'(rr ? oc1 : oc0), 16'(t.oc));
  endtask

  // Round-robin step with a transfer expected from channel ch.
  task automatic rr_xfer(input int idx, input logic [3:0] v, input int ch);
    vec_t t;
    t = '{1'b0, 4'b0010, v, 1'b1, 4'(1 << ch), 1'b1, chan_word(ch), 2'(ch)};
    step(1'b1, idx, t);
  endtask

  initial begin
    reset     = 1'b1;
    state     = 4'b0010;
    in_data   = D;
    in_valid  = 4'b0000;
    out_ready = 1'b0;

    tbl[0]  = '{1'b1, 4'b0010, 4'b1111, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0};
    tbl[1]  = '{1'b0, 4'b0010, 4'b1010, 1'b1, 4'b0010, 1'b1, 12'hABC, 2'd1};
    tbl[2]  = '{1'b0, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b1, 12'hABC, 2'd1};
    tbl[3]  = '{1'b0, 4'b0010, 4'b0100, 1'b1, 4'b0100, 1'b1, 12'h055, 2'd2};
    tbl[4]  = '{1'b0, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b1, 12'h055, 2'd2};
    tbl[5]  = '{1'b0, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b1, 12'h055, 2'd2};
    tbl[6]  = '{1'b0, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b1, 12'h055, 2'd2};
    tbl[7]  = '{1'b0, 4'b0010, 4'b0001, 1'b1, 4'b0001, 1'b1, 12'h011, 2'd0};
    tbl[8]  = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 12'h011, 2'd0};
    tbl[9]  = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 12'h011, 2'd0};
    tbl[10] = '{1'b0, 4'b0010, 4'b1000, 1'b0, 4'b1000, 1'b1, 12'h123, 2'd3};
    tbl[11] = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0};
    tbl[12] = '{1'b0, 4'b0001, 4'b1111, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0};
    tbl[13] = '{1'b0, 4'b0010, 4'b1100, 1'b1, 4'b0100, 1'b1, 12'h055, 2'd2};
    tbl[14] = '{1'b1, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0};
    tbl[15] = '{1'b0, 4'b0010, 4'b0110, 1'b1, 4'b0010, 1'b1, 12'hABC, 2'd1};

    for (int i = 0; i < 16; i++) begin
      step(1'b0, i, tbl[i]);
    end

    // Round-robin: continuous flow visits 0,1,2,3,0 with no bubble.
    step(1'b1, 100, '{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0});
    for (int k = 0; k < 5; k++) begin
      rr_xfer(101 + k, 4'b1111, k % 4);
    end

    // Wrap: ch2 leaves pointer at 3, lone ch0 wraps, then ch1 beats ch0.
    step(1'b1, 200, '{1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0});
    rr_xfer(201, 4'b0100, 2);
    rr_xfer(202, 4'b0001, 0);
    rr_xfer(203, 4'b0011, 1);
    rr_xfer(204, 4'b0001, 0);

    // Idle flush with all channels valid, then resume from held pointer 1.
    step(1'b1, 300, '{1'b0, 4'b0001, 4'b1111, 1'b1, 4'b0000, 1'b0, 12'h000, 2'd0});
    rr_xfer(301, 4'b1111, 1);

    // Reset while a word is pending: dropped, pointer back to 0.
    step(1'b1, 400, '{1'b1, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b0, 12'h000, 2'd0});
    rr_xfer(401, 4'b1111, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
